// File: rtl/booth_mult4.sv
// booth_mult4: sequential 4x4 signed radix-2 Booth multiplier with start/done handshake
//   Optional feature macro: BOOTH_BUSY_ABORT_EN (start while busy restarts from the current a/b)
//   Ports:
//     clk   - clock, rising edge
//     rst   - asynchronous active-high reset
//     start - request, accepted in IDLE or DONE
//     a, b  - signed 4-bit multiplicand / multiplier, captured on the accepting edge
//     busy  - high while iterations run
//     done  - one-cycle pulse when p updates
//     p     - signed 8-bit product, held until next completion or reset

// add_sub: 4-bit adder/subtractor stage, c0=1 subtracts b
module add_sub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       ovf
);
    logic [3:0] w_b;
    always_comb begin
        w_b = b ^ {4{c0}};
        s   = a + w_b + {3'b000, c0};
        ovf = (a[3] == w_b[3]) && (s[3] != a[3]);
    end
endmodule

module booth_mult4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     r_state;
    logic [3:0] r_a, r_q, r_m;
    logic       r_q1;
    logic [2:0] r_cnt;
    logic       r_busy, r_done;
    logic [7:0] r_p;
    logic [1:0] w_sel;
    logic       w_add;
    logic [3:0] w_sum, w_s, w_na, w_nq;
    logic       w_ovf, w_o;

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

    add_sub u_add_sub (.a(r_a), .b(r_m), .c0(w_sel == 2'b10), .s(w_sum), .ovf(w_ovf));

    always_comb begin
        w_sel = {r_q[0], r_q1};
        w_add = w_sel[1] ^ w_sel[0];
        w_s   = w_add ? w_sum : r_a;
        w_o   = w_add ? w_ovf : 1'b0;
        // shift in the true sign so an overflowing add/subtract (M=-8) stays correct
        w_na  = {w_s[3] ^ w_o, w_s[3:1]};
        w_nq  = {w_s[0], r_q[3:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= 4'd0;
            r_q     <= 4'd0;
            r_m     <= 4'd0;
            r_q1    <= 1'b0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= 8'h00;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_a     <= 4'd0;
                        r_q     <= b;
                        r_m     <= a;
                        r_q1    <= 1'b0;
                        r_cnt   <= 3'd0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
`ifdef BOOTH_BUSY_ABORT_EN
                    if (start) begin
                        r_a   <= 4'd0;
                        r_q   <= b;
                        r_m   <= a;
                        r_q1  <= 1'b0;
                        r_cnt <= 3'd0;
                    end else
`endif
                    begin
                        r_a   <= w_na;
                        r_q   <= w_nq;
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd3) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_p     <= {w_na, w_nq};
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
